// File: rtl/imem_fetch_ctrl_pkg.sv
// imem_fetch_ctrl_pkg
//   Shared definitions for the instruction fetch controller:
//   fetch state encoding, fetch queue depth and the default reset PC.
package imem_fetch_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    localparam int          FIFO_DEPTH       = 2;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// fetch_fifo
//   Two-entry queue of {instr, pc} between the ROM and the decode stage.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     push/push_instr/pc    write one entry (accepted if not full or popping)
//     pop                   retire the head entry (ignored when empty)
//     flush                 drop all entries; wins over push/pop
//     head_instr/head_pc    head entry, zero when empty
//     empty, full           occupancy flags
import imem_fetch_ctrl_pkg::*;

module fetch_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_instr,
    input  logic [W-1:0] push_pc,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head_instr,
    output logic [W-1:0] head_pc,
    output logic         empty,
    output logic         full
);

    logic [FIFO_DEPTH-1:0][W-1:0] instr_q, instr_d;
    logic [FIFO_DEPTH-1:0][W-1:0] pc_q, pc_d;
    logic                         rd_ptr_q, rd_ptr_d;
    logic [1:0]                   cnt_q, cnt_d;
    logic                         wr_ptr;
    logic                         do_push, do_pop;

    assign empty = (cnt_q == 2'd0);
    assign full  = (cnt_q == 2'd2);

    assign head_instr = empty ? '0 : instr_q[rd_ptr_q];
    assign head_pc    = empty ? '0 : pc_q[rd_ptr_q];

    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        // With two slots the write slot is rd_ptr + cnt (mod 2); when full and
        // popping this lands on the head slot that is leaving this cycle.
        wr_ptr   = rd_ptr_q ^ cnt_q[0];
        if (flush) begin
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (do_push) begin
                instr_d[wr_ptr] = push_instr;
                pc_d[wr_ptr]    = push_pc;
            end
            if (do_pop) rd_ptr_d = ~rd_ptr_q;
            cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q  <= '0;
            pc_q     <= '0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Sequential instruction fetch from a combinational ROM into a 2-entry
//   queue feeding decode, with redirect (flush + refetch) and a sticky FAULT
//   state on misaligned or out-of-range fetch addresses.
//   Ports:
//     clk, rst_n                      clock, synchronous active-low reset
//     rom_adr / rom_dout              ROM byte address out, word back same cycle
//     id_valid/id_instr/id_pc         head queue entry to decode
//     id_ready                        decode accepts head this cycle
//     redirect / redirect_pc          flush queue and restart fetch
//     fault / fault_pc                fetch stopped, offending address
//     fetch_cnt                       instructions accepted by decode (wraps)
import imem_fetch_ctrl_pkg::*;

module imem_fetch_ctrl #(
    parameter int            N        = 64,
    parameter int            M        = 32,
    parameter logic [M-1:0]  RESET_PC = M'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [M-1:0] rom_adr,
    input  logic [M-1:0] rom_dout,
    input  logic         id_ready,
    output logic         id_valid,
    output logic [M-1:0] id_instr,
    output logic [M-1:0] id_pc,
    input  logic         redirect,
    input  logic [M-1:0] redirect_pc,
    output logic         fault,
    output logic [M-1:0] fault_pc,
    output logic [M-1:0] fetch_cnt
);

    // One past the last legal byte address; one extra bit so N*4 == 2^M works.
    localparam logic [M:0] FETCH_LIMIT = (M+1)'(N * 4);

    fetch_state_e state_q, state_d;
    logic [M-1:0] pc_q, pc_d;
    logic         fault_q, fault_d;
    logic [M-1:0] fault_pc_q, fault_pc_d;
    logic [M-1:0] fetch_cnt_q, fetch_cnt_d;

    logic         fifo_push, fifo_pop, fifo_flush;
    logic         fifo_empty, fifo_full;
    logic         fetch_legal;

    fetch_fifo #(.W(M)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_instr (rom_dout),
        .push_pc    (pc_q),
        .pop        (fifo_pop),
        .flush      (fifo_flush),
        .head_instr (id_instr),
        .head_pc    (id_pc),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    assign rom_adr   = pc_q;
    assign id_valid  = !fifo_empty;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;
    assign fetch_cnt = fetch_cnt_q;

    assign fifo_pop    = id_valid && id_ready;
    assign fetch_legal = (pc_q[1:0] == 2'b00) && ({1'b0, pc_q} < FETCH_LIMIT);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fault_d     = fault_q;
        fault_pc_d  = fault_pc_q;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
        // A handshake in a redirect cycle still counts before the flush.
        fetch_cnt_d = fifo_pop ? fetch_cnt_q + M'(1) : fetch_cnt_q;

        if (redirect) begin
            fifo_flush = 1'b1;
            pc_d       = redirect_pc;
            state_d    = ST_RUN;
            fault_d    = 1'b0;
            fault_pc_d = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (!fetch_legal) begin
                        state_d    = ST_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                    end else if (!fifo_full || fifo_pop) begin
                        fifo_push = 1'b1;
                        pc_d      = pc_q + M'(4);
                    end
                end
                // Queue keeps draining through the handshake; nothing is fetched.
                ST_FAULT: ;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            fault_q     <= 1'b0;
            fault_pc_q  <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fault_q     <= fault_d;
            fault_pc_q  <= fault_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rom_adr, rom_dout;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr, id_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fault;
    logic [31:0] fault_pc, fetch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.N(64), .M(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_adr     (rom_adr),
        .rom_dout    (rom_dout),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fault       (fault),
        .fault_pc    (fault_pc),
        .fetch_cnt   (fetch_cnt)
    );

    // ROM: word 0/1 fixed, others tagged with their word index.
    function automatic logic [31:0] rom_word(input logic [31:0] adr);
        logic [31:0] idx;
        idx = adr >> 2;
        if (idx == 0)      return 32'h2008_0005;
        else if (idx == 1) return 32'h2009_0003;
        else               return 32'hA000_0000 | idx;
    endfunction

    always_comb rom_dout = rom_word(rom_adr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst_n, rdy, redir;
        logic [31:0] rpc;
        logic        e_vld;
        logic [31:0] e_pc, e_instr, e_adr;
        logic        e_flt;
        logic [31:0] e_fpc, e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc,
                                input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                input logic [31:0] adr, input logic f, input logic [31:0] fpc,
                                input logic [31:0] cnt);
        vec_t t;
        t.rst_n = r; t.rdy = rdy; t.redir = rd; t.rpc = rpc;
        t.e_vld = v; t.e_pc = pc; t.e_instr = ins; t.e_adr = adr;
        t.e_flt = f; t.e_fpc = fpc; t.e_cnt = cnt;
        return t;
    endfunction

    initial begin
        bit got;
        // reset, then basic streaming with decode always ready
        vecs.push_back(mk(0,0,0,0,     0,32'h0,32'h0,32'h0,0,0,0));
        vecs.push_back(mk(1,1,0,0,     1,32'h0,32'h20080005,32'h4,0,0,0));
        vecs.push_back(mk(1,1,0,0,     1,32'h4,32'h20090003,32'h8,0,0,1));
        vecs.push_back(mk(1,1,0,0,     1,32'h8,32'hA0000002,32'hC,0,0,2));
        // reset, decode stalled 5 cycles: queue fills with 0x0/0x4, rom_adr holds 0x8
        vecs.push_back(mk(0,0,0,0,     0,32'h0,32'h0,32'h0,0,0,0));
        vecs.push_back(mk(1,0,0,0,     1,32'h0,32'h20080005,32'h4,0,0,0));
        vecs.push_back(mk(1,0,0,0,     1,32'h0,32'h20080005,32'h8,0,0,0));
        vecs.push_back(mk(1,0,0,0,     1,32'h0,32'h20080005,32'h8,0,0,0));
        vecs.push_back(mk(1,0,0,0,     1,32'h0,32'h20080005,32'h8,0,0,0));
        vecs.push_back(mk(1,0,0,0,     1,32'h0,32'h20080005,32'h8,0,0,0));
        // full queue: push and pop together
        vecs.push_back(mk(1,1,0,0,     1,32'h4,32'h20090003,32'hC,0,0,1));
        vecs.push_back(mk(1,1,0,0,     1,32'h8,32'hA0000002,32'h10,0,0,2));
        // redirect while head 0x8 accepted: counted, 0xC dropped
        vecs.push_back(mk(1,1,1,32'h40, 0,32'h0,32'h0,32'h40,0,0,3));
        vecs.push_back(mk(1,0,0,0,     1,32'h40,32'hA0000010,32'h44,0,0,3));
        // misaligned redirect target faults the following cycle
        vecs.push_back(mk(1,0,1,32'h6,  0,32'h0,32'h0,32'h6,0,0,3));
        vecs.push_back(mk(1,0,0,0,     0,32'h0,32'h0,32'h6,1,32'h6,3));
        vecs.push_back(mk(1,1,0,0,     0,32'h0,32'h0,32'h6,1,32'h6,3));
        // run off the end of the ROM
        vecs.push_back(mk(1,0,1,32'hF8, 0,32'h0,32'h0,32'hF8,0,0,3));
        vecs.push_back(mk(1,0,0,0,     1,32'hF8,32'hA000003E,32'hFC,0,0,3));
        vecs.push_back(mk(1,0,0,0,     1,32'hF8,32'hA000003E,32'h100,0,0,3));
        vecs.push_back(mk(1,0,0,0,     1,32'hF8,32'hA000003E,32'h100,1,32'h100,3));
        vecs.push_back(mk(1,1,0,0,     1,32'hFC,32'hA000003F,32'h100,1,32'h100,4));
        vecs.push_back(mk(1,1,0,0,     0,32'h0,32'h0,32'h100,1,32'h100,5));
        vecs.push_back(mk(1,1,0,0,     0,32'h0,32'h0,32'h100,1,32'h100,5));
        vecs.push_back(mk(1,0,1,32'h0,  0,32'h0,32'h0,32'h0,0,0,5));
        vecs.push_back(mk(1,0,0,0,     1,32'h0,32'h20080005,32'h4,0,0,5));
        // fault with full queue, then reset that also carries redirect+handshake
        vecs.push_back(mk(1,0,1,32'hF8, 0,32'h0,32'h0,32'hF8,0,0,5));
        vecs.push_back(mk(1,0,0,0,     1,32'hF8,32'hA000003E,32'hFC,0,0,5));
        vecs.push_back(mk(1,0,0,0,     1,32'hF8,32'hA000003E,32'h100,0,0,5));
        vecs.push_back(mk(1,0,0,0,     1,32'hF8,32'hA000003E,32'h100,1,32'h100,5));
        vecs.push_back(mk(0,1,1,32'h40, 0,32'h0,32'h0,32'h0,0,0,0));
        vecs.push_back(mk(1,0,0,0,     1,32'h0,32'h20080005,32'h4,0,0,0));
        vecs.push_back(mk(1,1,0,0,     1,32'h4,32'h20090003,32'h8,0,0,1));

        #2;
        foreach (vecs[i]) begin
            rst_n       = vecs[i].rst_n;
            id_ready    = vecs[i].rdy;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            tick();
            chk($sformatf("v%0d id_valid", i),  {31'b0, id_valid}, {31'b0, vecs[i].e_vld});
            chk($sformatf("v%0d id_pc", i),     id_pc,     vecs[i].e_pc);
            chk($sformatf("v%0d id_instr", i),  id_instr,  vecs[i].e_instr);
            chk($sformatf("v%0d rom_adr", i),   rom_adr,   vecs[i].e_adr);
            chk($sformatf("v%0d fault", i),     {31'b0, fault}, {31'b0, vecs[i].e_flt});
            chk($sformatf("v%0d fault_pc", i),  fault_pc,  vecs[i].e_fpc);
            chk($sformatf("v%0d fetch_cnt", i), fetch_cnt, vecs[i].e_cnt);
        end

        // Aligned but out-of-range redirect: bounded wait for the fault.
        // Head 0x4 is accepted in the redirect cycle (count 1 -> 2).
        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h3FC;
        tick();
        chk("oor redirect rom_adr", rom_adr, 32'h3FC);
        chk("oor redirect fault", {31'b0, fault}, 32'h0);
        redirect = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            tick();
            if (fault) got = 1'b1;
        end
        chk("oor fault seen", {31'b0, got}, 32'h1);
        chk("oor fault_pc", fault_pc, 32'h3FC);
        chk("oor id_valid", {31'b0, id_valid}, 32'h0);
        chk("oor fetch_cnt", fetch_cnt, 32'h2);

        // Recover from fault via redirect to 0x4 with decode ready.
        redirect = 1'b1; redirect_pc = 32'h4;
        tick();
        chk("rec fault clr", {31'b0, fault}, 32'h0);
        chk("rec fault_pc clr", fault_pc, 32'h0);
        redirect = 1'b0;
        tick();
        chk("rec first pc", id_pc, 32'h4);
        chk("rec first instr", id_instr, 32'h20090003);
        tick();
        chk("rec second pc", id_pc, 32'h8);
        chk("rec cnt", fetch_cnt, 32'h3);
        chk("rec rom_adr", rom_adr, 32'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
